mod_red_sm2_p: RTL
==================

MOD_RED_SM2_P -- requirements
Module: mod_red_sm2_p

Interface
REQ-001 The block SHALL have no parameters; the SM2 prime p = FFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF (hex) is a fixed constant.
REQ-002 The block SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port red_vld_i, input, 1 bit: red_x_i is valid this cycle.
REQ-006 The block SHALL have port red_x_i, input, 512 bits: unsigned operand, the full-width 256x256 product.
REQ-007 The block SHALL have port red_fin_o, output, 1 bit: red_r_o is valid this cycle (single-cycle pulse per result).
REQ-008 The block SHALL have port red_r_o, output, 256 bits: red_x_i mod p, fully reduced to 0..p-1.

Function
REQ-009 The block SHALL be a 3-stage pipeline with fixed latency of 3 clk: input sampled at edge N appears on red_r_o with red_fin_o=1 after edge N+3.
REQ-010 The block SHALL accept a new operand every cycle, with no backpressure and no stall.
REQ-011 The block SHALL carry a valid bit per stage (vld_s1..vld_s3), shifting each cycle; red_fin_o SHALL equal vld_s3.
REQ-012 Stage 1 SHALL split red_x_i into 32-bit words c0..c15 and form T = Solinas SM2 word-sum plus a constant multiple of p, such that 0 <= T < 16p; T register width is 261 bits; T is congruent to red_x_i mod p.
REQ-013 Stage 2 SHALL compute k = floor(T / 2^256) (0..15), subtract k*p taken from a 16-entry constant table, and register U with 0 <= U < 3p in 258 bits.
REQ-014 Stage 3 SHALL subtract p from U conditionally, up to twice, using parallel comparisons of U, U-p and U-2p (no iteration), and register the result into red_r_o.
REQ-015 The block SHALL be correct for every 512-bit input, including inputs >= p^2 and 2^512-1.
REQ-016 Data registers SHALL update every cycle regardless of valid; red_r_o is meaningful only when red_fin_o=1.
REQ-017 red_r_o SHALL hold its last value while red_fin_o=0 only if no new data enters; otherwise its value is don't-care.
REQ-018 Back-to-back valid inputs SHALL produce back-to-back red_fin_o pulses in the same order, one result per input.
REQ-019 red_vld_i asserted in the same cycle as result emission SHALL not disturb the emitted result.

Reset
REQ-020 On rst_n=0, vld_s1..vld_s3 and red_fin_o SHALL clear to 0 and red_r_o SHALL clear to 256'd0 immediately, asynchronously.
REQ-021 On rst_n=0, all stage data registers SHALL clear to 0.
REQ-022 Operands in flight when reset asserts SHALL be discarded, with no red_fin_o pulse for them after reset release.
REQ-023 The first input accepted after reset release SHALL emit 3 cycles later.

Structure
REQ-024 The SM2 constants SHALL live in the shared SM2 package, not in this module: p, the 16-entry k*p table, and the stage-1 offset multiple of p.
REQ-025 Stage 1 word-sum SHALL be a sub-module sm2_solinas_sum (combinational; 512b in, 261b out); stages 2-3 and the valid pipeline stay in mod_red_sm2_p.
REQ-026 The block SHALL connect directly to the 512-bit output of the 256b full-width multiplier, with that multiplier's registered product feeding red_x_i and its valid feeding red_vld_i.

Verification
REQ-027 Scenario: red_x_i=0, vld 1 cycle -> red_fin_o pulse 3 cycles later with red_r_o=0.
REQ-028 Scenario: red_x_i=p -> 0; red_x_i=p-1 -> p-1; red_x_i=2^256 -> 00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001 (hex, i.e. 2^224+2^96-2^64+1).
REQ-029 Scenario: red_x_i=(p-1)^2 -> red_r_o=1; red_x_i=2^512-1 -> red_r_o equals the golden model (2^512-1) mod p.
REQ-030 Scenario: 1000 back-to-back random 512-bit inputs with red_vld_i held high -> 1000 consecutive red_fin_o pulses, in order, each matching the golden mod p model.
REQ-031 Scenario: inputs fed at cycles 0,1,2, with rst_n pulsed low at cycle 2 -> no red_fin_o pulse for any of them, and red_r_o=0 during reset; a new input after release emits exactly 3 cycles later.
REQ-032 Scenario: random gaps in red_vld_i -> the red_fin_o pattern equals red_vld_i delayed by 3 cycles.

Source files
------------

// File: rtl/mod_red_sm2_p_pkg.sv
// SM2 prime constants shared by the modular-reduction pipeline.
// Widths, p, its multiples, and the stage-2 table of k*p values.
package mod_red_sm2_p_pkg;

  localparam int X_W   = 512;
  localparam int R_W   = 256;
  localparam int T_W   = 261;
  localparam int U_W   = 258;
  localparam int COL_W = 36;

  localparam logic [R_W-1:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  // One p added to the word-sum covers the largest negative term (< 4*2^96).
  localparam logic [T_W-1:0] SM2_T_OFFSET = {{(T_W-R_W){1'b0}}, SM2_P};

  localparam logic [U_W-1:0] SM2_P_U  = {2'b00, SM2_P};
  localparam logic [U_W-1:0] SM2_2P_U = {1'b0, SM2_P, 1'b0};

  // Entries are k*p modulo 2^258: U is formed in 258 bits and is known to fit.
  localparam logic [U_W-1:0] SM2_KP_TAB [16] = '{
    SM2_P_U * U_W'(0),  SM2_P_U * U_W'(1),  SM2_P_U * U_W'(2),  SM2_P_U * U_W'(3),
    SM2_P_U * U_W'(4),  SM2_P_U * U_W'(5),  SM2_P_U * U_W'(6),  SM2_P_U * U_W'(7),
    SM2_P_U * U_W'(8),  SM2_P_U * U_W'(9),  SM2_P_U * U_W'(10), SM2_P_U * U_W'(11),
    SM2_P_U * U_W'(12), SM2_P_U * U_W'(13), SM2_P_U * U_W'(14), SM2_P_U * U_W'(15)
  };

endpackage

// File: rtl/sm2_solinas_sum.sv
// Combinational SM2 Solinas fold: 512-bit product to T with 0 <= T < 16p, T == x mod p.
// Each high word c8..c15 is replaced by its 2^(32i) mod p expansion over the low eight words.
module sm2_solinas_sum
  import mod_red_sm2_p_pkg::*;
(
  input  logic [X_W-1:0] x,
  output logic [T_W-1:0] t
);

  logic [COL_W-1:0] c   [16];
  logic [COL_W-1:0] col [8];
  logic [COL_W-1:0] neg_col;
  logic [T_W-1:0]   pos;

  always_comb begin
    for (int i = 0; i < 16; i++) c[i] = {4'b0000, x[32*i +: 32]};
  end

  // Column j collects every positive contribution to word j of the 256-bit result.
  always_comb begin
    col[0] = c[0] + c[8] + c[9] + c[10] + c[11] + c[12]
           + (c[13] << 1) + (c[14] << 1) + (c[15] << 1);
    col[1] = c[1] + c[9] + c[10] + c[11] + c[12] + c[13]
           + (c[14] << 1) + (c[15] << 1);
    col[2] = c[2];
    col[3] = c[3] + c[8] + c[11] + c[12] + (c[13] << 1) + c[14] + c[15];
    col[4] = c[4] + c[9] + c[12] + c[13] + (c[14] << 1) + c[15];
    col[5] = c[5] + c[10] + c[13] + c[14] + (c[15] << 1);
    col[6] = c[6] + c[11] + c[14] + c[15];
    col[7] = c[7] + c[8] + c[9] + c[10] + c[11]
           + (c[12] << 1) + (c[13] << 1) + (c[14] << 1) + (c[15] << 1) + c[15];
    neg_col = c[8] + c[9] + c[13] + c[14];
    pos = '0;
    for (int j = 0; j < 8; j++) begin
      pos = pos + ({{(T_W-COL_W){1'b0}}, col[j]} << (32*j));
    end
    t = pos + SM2_T_OFFSET - ({{(T_W-COL_W){1'b0}}, neg_col} << 64);
  end

endmodule

// File: rtl/mod_red_sm2_p.sv
// Three-stage SM2 modular reduction: Solinas fold, k*p table subtract, final conditional subtract.
// Accepts one operand per cycle, fixed 3-cycle latency, no backpressure.
module mod_red_sm2_p
  import mod_red_sm2_p_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           red_vld_i,
  input  logic [X_W-1:0] red_x_i,
  output logic           red_fin_o,
  output logic [R_W-1:0] red_r_o
);

  // Valid semantics: red_vld_i qualifies red_x_i on the sampling edge; there is no ready,
  // every valid is accepted, and red_fin_o is a one-cycle qualifier for red_r_o.
  logic           vld_s1, vld_s2, vld_s3;
  logic [T_W-1:0] t_d, t_q;
  logic [3:0]     k;
  logic [U_W-1:0] u_d, u_q;
  logic           ge_p, ge_2p;
  logic [R_W-1:0] d1, d2, r_d;
  logic           unused_t_msb;

  sm2_solinas_sum u_sum (
    .x (red_x_i),
    .t (t_d)
  );

  // T < 2^260, so the top bit is always zero and k = T / 2^256 fits in four bits.
  assign k            = t_q[R_W+3:R_W];
  assign unused_t_msb = t_q[T_W-1];
  assign u_d          = t_q[U_W-1:0] - SM2_KP_TAB[k];

  assign ge_p  = (u_q >= SM2_P_U);
  assign ge_2p = (u_q >= SM2_2P_U);
  assign d1    = u_q[R_W-1:0] - SM2_P;
  assign d2    = u_q[R_W-1:0] - SM2_2P_U[R_W-1:0];

  always_comb begin
    r_d = u_q[R_W-1:0];
    if (ge_2p)     r_d = d2;
    else if (ge_p) r_d = d1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_s1  <= 1'b0;
      vld_s2  <= 1'b0;
      vld_s3  <= 1'b0;
      t_q     <= '0;
      u_q     <= '0;
      red_r_o <= '0;
    end else begin
      vld_s1  <= red_vld_i;
      vld_s2  <= vld_s1;
      vld_s3  <= vld_s2;
      t_q     <= t_d;
      u_q     <= u_d;
      red_r_o <= r_d;
    end
  end

  assign red_fin_o = vld_s3;

endmodule
